// File: rtl/sr_latch_monitor.sv
// SR-latch observer: tracks a reference model of the latch from the S/R
// stimulus, checks Q/nQ a fixed number of edges after every stimulus change,
// and keeps saturating counts of checks, failed checks and S=R=1 entries.
module sr_latch_monitor #(
  parameter int unsigned SETTLE_CYCLES = 2,   // legal range 1..255
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             s_i,
  input  logic             r_i,
  input  logic             q_i,
  input  logic             nq_i,
  output logic             err_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic [CNT_W-1:0] forbid_cnt_o,
  output logic [CNT_W-1:0] check_cnt_o,
  output logic             model_q_o,
  output logic             model_valid_o,
  output logic [1:0]       state_o
);

  localparam logic [1:0] ST_UNKNOWN = 2'd0;
  localparam logic [1:0] ST_SETTLE  = 2'd1;
  localparam logic [1:0] ST_STABLE  = 2'd2;
  localparam logic [1:0] ST_FORBID  = 2'd3;

  // Settle counter is loaded with SETTLE_CYCLES-1 so the check lands exactly
  // SETTLE_CYCLES edges after the edge that sampled the change.
  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

  // Saturating increment: an all-ones counter stays put instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + CNT_W'(1);
    end
  endfunction

  logic [1:0]       state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [1:0]       sr_prev_q, sr_prev_d;
  logic             model_q_q, model_q_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] forbid_cnt_q, forbid_cnt_d;
  logic [CNT_W-1:0] check_cnt_q, check_cnt_d;

  logic [1:0] sr_s;
  logic       chg_s;
  logic       check_s;
  logic       fail_s;

  assign sr_s   = {s_i, r_i};
  assign chg_s  = (sr_s != sr_prev_q);
  assign fail_s = (q_i != model_q_q) || (nq_i == q_i);

  // Next-state logic: stimulus changes dominate, otherwise the settle count runs down.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    check_s = 1'b0;
    if (chg_s) begin
      if (sr_s == 2'b11) begin
        state_d = ST_FORBID;
      end else if ((state_q == ST_FORBID) && (sr_s == 2'b00)) begin
        // Leaving S=R=1 straight to hold is a race: latch output undefined.
        state_d = ST_UNKNOWN;
      end else begin
        state_d = ST_SETTLE;
        cnt_d   = SETTLE_LOAD;
      end
    end else if (state_q == ST_SETTLE) begin
      if (cnt_q != 8'd0) begin
        cnt_d = cnt_q - 8'd1;
      end else begin
        state_d = ST_STABLE;
        check_s = 1'b1;
      end
    end else begin
      state_d = state_q;
    end
  end

  // Output/datapath logic: reference model, check result and event counters.
  always_comb begin
    sr_prev_d    = sr_s;
    model_q_d    = model_q_q;
    valid_d      = valid_q;
    err_d        = 1'b0;
    err_cnt_d    = err_cnt_q;
    forbid_cnt_d = forbid_cnt_q;
    check_cnt_d  = check_cnt_q;
    if (chg_s) begin
      case (sr_s)
        2'b10: begin
          model_q_d = 1'b1;
          valid_d   = 1'b1;
        end
        2'b01: begin
          model_q_d = 1'b0;
          valid_d   = 1'b1;
        end
        2'b11: begin
          valid_d      = 1'b0;
          forbid_cnt_d = sat_inc(forbid_cnt_q);
        end
        default: begin
          model_q_d = model_q_q;
          valid_d   = valid_q;
        end
      endcase
    end else begin
      model_q_d = model_q_q;
    end
    if (check_s && valid_q) begin
      check_cnt_d = sat_inc(check_cnt_q);
      if (fail_s) begin
        err_d     = 1'b1;
        err_cnt_d = sat_inc(err_cnt_q);
      end else begin
        err_d = 1'b0;
      end
    end else begin
      err_d = 1'b0;
    end
  end

  // State register with synchronous reset; reset also drops any pending check.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_UNKNOWN;
      cnt_q        <= 8'd0;
      sr_prev_q    <= 2'b00;
      model_q_q    <= 1'b0;
      valid_q      <= 1'b0;
      err_q        <= 1'b0;
      err_cnt_q    <= '0;
      forbid_cnt_q <= '0;
      check_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sr_prev_q    <= sr_prev_d;
      model_q_q    <= model_q_d;
      valid_q      <= valid_d;
      err_q        <= err_d;
      err_cnt_q    <= err_cnt_d;
      forbid_cnt_q <= forbid_cnt_d;
      check_cnt_q  <= check_cnt_d;
    end
  end

  assign err_o         = err_q;
  assign err_cnt_o     = err_cnt_q;
  assign forbid_cnt_o  = forbid_cnt_q;
  assign check_cnt_o   = check_cnt_q;
  assign model_q_o     = model_q_q;
  assign model_valid_o = valid_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_sr_latch_monitor.sv
// Directed bench for sr_latch_monitor: a default instance (SETTLE_CYCLES=2,
// CNT_W=16) and a narrow-counter instance (CNT_W=2) share the stimulus.
module tb_sr_latch_monitor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic s = 1'b0, r = 1'b0, q = 1'b0, nq = 1'b0;

  logic        err;
  logic [15:0] err_cnt, forbid_cnt, check_cnt;
  logic        model_q, model_valid;
  logic [1:0]  state;

  logic        err_n;
  logic [1:0]  err_cnt_n, forbid_cnt_n, check_cnt_n;
  logic        model_q_n, model_valid_n;
  logic [1:0]  state_n;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sr_latch_monitor #(.SETTLE_CYCLES(2), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .s_i(s), .r_i(r), .q_i(q), .nq_i(nq),
    .err_o(err), .err_cnt_o(err_cnt), .forbid_cnt_o(forbid_cnt),
    .check_cnt_o(check_cnt), .model_q_o(model_q),
    .model_valid_o(model_valid), .state_o(state)
  );

  sr_latch_monitor #(.SETTLE_CYCLES(2), .CNT_W(2)) dut_sat (
    .clk_i(clk), .rst_i(rst), .s_i(s), .r_i(r), .q_i(q), .nq_i(nq),
    .err_o(err_n), .err_cnt_o(err_cnt_n), .forbid_cnt_o(forbid_cnt_n),
    .check_cnt_o(check_cnt_n), .model_q_o(model_q_n),
    .model_valid_o(model_valid_n), .state_o(state_n)
  );

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; s = 1'b0; r = 1'b0; q = 1'b0; nq = 1'b0;
    tick();
    tick();
    n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d exp 0", state); end
    n_checks++; if ({err, model_q, model_valid} !== 3'b000) begin n_fail++; $display("FAIL reset_bits: got %b exp 000", {err, model_q, model_valid}); end
    n_checks++; if ({err_cnt, forbid_cnt, check_cnt} !== 48'd0) begin n_fail++; $display("FAIL reset_cnts: got %h exp 0", {err_cnt, forbid_cnt, check_cnt}); end
    rst = 1'b0;
    tick();
    n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL release_state: got %0d exp 0", state); end
    n_checks++; if ({err, check_cnt} !== 17'd0) begin n_fail++; $display("FAIL release_out: got %h exp 0", {err, check_cnt}); end
  endtask

  task automatic test_set_pass();
    s = 1'b1; q = 1'b1; nq = 1'b0;
    tick();  // change to 10
    n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL set_settle: got %0d exp 1", state); end
    n_checks++; if ({model_q, model_valid} !== 2'b11) begin n_fail++; $display("FAIL set_model: got %b exp 11", {model_q, model_valid}); end
    s = 1'b0;
    tick();  // change to 00 restarts settle
    tick();
    n_checks++; if (state !== 2'd1 || check_cnt !== 16'd0) begin n_fail++; $display("FAIL set_pending: got st %0d cc %0d exp 1/0", state, check_cnt); end
    tick();  // check edge
    n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL set_stable: got %0d exp 2", state); end
    n_checks++; if (check_cnt !== 16'd1) begin n_fail++; $display("FAIL set_check_cnt: got %0d exp 1", check_cnt); end
    n_checks++; if (err !== 1'b0 || err_cnt !== 16'd0) begin n_fail++; $display("FAIL set_err: got %b/%0d exp 0/0", err, err_cnt); end
    tick();
    n_checks++; if (err !== 1'b0 || model_q !== 1'b1) begin n_fail++; $display("FAIL set_after: got err %b mq %b exp 0/1", err, model_q); end
  endtask

  task automatic test_fail_pulse();
    r = 1'b1;       // q stays 1: mismatch against model 0
    tick();
    n_checks++; if (model_q !== 1'b0) begin n_fail++; $display("FAIL fail_model: got %b exp 0", model_q); end
    r = 1'b0;
    tick();         // last change edge
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL fail_early0: got %b exp 0", err); end
    tick();
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL fail_early1: got %b exp 0", err); end
    tick();         // check edge
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL fail_pulse: got %b exp 1", err); end
    n_checks++; if (err_cnt !== 16'd1 || check_cnt !== 16'd2) begin n_fail++; $display("FAIL fail_cnts: got %0d/%0d exp 1/2", err_cnt, check_cnt); end
    tick();
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL fail_one_cycle: got %b exp 0", err); end
    q = 1'b0; nq = 1'b1;
  endtask

  task automatic test_forbid();
    s = 1'b1; r = 1'b1;
    tick();
    n_checks++; if (state !== 2'd3) begin n_fail++; $display("FAIL forbid_state: got %0d exp 3", state); end
    n_checks++; if (forbid_cnt !== 16'd1 || model_valid !== 1'b0) begin n_fail++; $display("FAIL forbid_cnt: got %0d v %b exp 1/0", forbid_cnt, model_valid); end
    tick();
    n_checks++; if (state !== 2'd3 || forbid_cnt !== 16'd1) begin n_fail++; $display("FAIL forbid_hold: got %0d/%0d exp 3/1", state, forbid_cnt); end
    s = 1'b0; r = 1'b0;
    tick();
    n_checks++; if (state !== 2'd0 || model_valid !== 1'b0) begin n_fail++; $display("FAIL forbid_exit: got %0d v %b exp 0/0", state, model_valid); end
    tick();
    tick();
    n_checks++; if (check_cnt !== 16'd2 || state !== 2'd0) begin n_fail++; $display("FAIL forbid_nocheck: got cc %0d st %0d exp 2/0", check_cnt, state); end
  endtask

  task automatic test_back_to_back();
    q = 1'b1; nq = 1'b0;
    for (int i = 0; i < 6; i++) begin
      s = (i % 2 == 0) ? 1'b1 : 1'b0;
      tick();
      n_checks++; if (state !== 2'd1 || check_cnt !== 16'd2) begin n_fail++; $display("FAIL b2b_settle%0d: got st %0d cc %0d exp 1/2", i, state, check_cnt); end
    end
    tick();
    n_checks++; if (check_cnt !== 16'd2) begin n_fail++; $display("FAIL b2b_early: got %0d exp 2", check_cnt); end
    tick();
    n_checks++; if (check_cnt !== 16'd3 || state !== 2'd2) begin n_fail++; $display("FAIL b2b_check: got cc %0d st %0d exp 3/2", check_cnt, state); end
    n_checks++; if (err_cnt !== 16'd1) begin n_fail++; $display("FAIL b2b_err: got %0d exp 1", err_cnt); end
    tick();
    tick();
    n_checks++; if (check_cnt !== 16'd3) begin n_fail++; $display("FAIL b2b_single: got %0d exp 3", check_cnt); end
  endtask

  task automatic test_saturate();
    rst = 1'b1; s = 1'b0; r = 1'b0;
    tick();
    rst = 1'b0;
    q = 1'b0; nq = 1'b0;   // nq == q: every check fails
    for (int i = 0; i < 5; i++) begin
      s = (i % 2 == 0) ? 1'b1 : 1'b0;
      r = (i % 2 == 0) ? 1'b0 : 1'b1;
      tick();
      tick();
      tick();
    end
    n_checks++; if (err_cnt_n !== 2'd3) begin n_fail++; $display("FAIL sat_err_cnt: got %0d exp 3", err_cnt_n); end
    n_checks++; if (check_cnt_n !== 2'd3) begin n_fail++; $display("FAIL sat_check_cnt: got %0d exp 3", check_cnt_n); end
    n_checks++; if (err_cnt !== 16'd5 || check_cnt !== 16'd5) begin n_fail++; $display("FAIL wide_cnts: got %0d/%0d exp 5/5", err_cnt, check_cnt); end
  endtask

  task automatic test_reset_mid();
    s = 1'b0; r = 1'b1; q = 1'b1; nq = 1'b0;   // pending check would fail
    tick();
    n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL mid_settle: got %0d exp 1", state); end
    rst = 1'b1;
    tick();
    s = 1'b0; r = 1'b0;
    rst = 1'b0;
    n_checks++; if ({err_cnt, forbid_cnt, check_cnt} !== 48'd0 || state !== 2'd0) begin n_fail++; $display("FAIL mid_reset: got %h st %0d exp 0/0", {err_cnt, forbid_cnt, check_cnt}, state); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (err !== 1'b0 || err_cnt !== 16'd0 || check_cnt !== 16'd0) begin n_fail++; $display("FAIL mid_quiet%0d: got %b/%0d/%0d exp 0/0/0", i, err, err_cnt, check_cnt); end
    end
  endtask

  initial begin
    test_reset();
    test_set_pass();
    test_fail_pulse();
    test_forbid();
    test_back_to_back();
    test_saturate();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
